// File: rtl/dual_buffer_sched_pkg.sv
// Shared definitions for the dual-buffer scheduler.
// Holds the symbol constants that split the input stream into
// luggage / passenger / end, the 2-bit symbol class encoding and the
// 3-bit FSM state encoding.
package dual_buffer_sched_pkg;

  localparam logic [7:0] LUG_MIN = 8'h31;  // '1'
  localparam logic [7:0] LUG_MAX = 8'h39;  // '9'
  localparam logic [7:0] END_SYM = 8'h24;  // '$'

  typedef enum logic [1:0] {
    SYM_LUGGAGE   = 2'b00,
    SYM_PASSENGER = 2'b01,
    SYM_END       = 2'b10
  } sym_class_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCEPT     = 3'd1,
    DRAIN_FIFO = 3'd2,
    DRAIN_LIFO = 3'd3,
    DONE       = 3'd4
  } state_e;

endpackage

// File: rtl/dual_buffer_sched_symbol_classify.sv
// Combinational symbol classifier.
//   data_in   : incoming symbol
//   sym_class : LUGGAGE for '1'..'9', END for '$', PASSENGER otherwise
module symbol_classify
  import dual_buffer_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  output sym_class_e            sym_class
);

  always_comb begin
    sym_class = SYM_PASSENGER;
    if (data_in == DATA_WIDTH'(END_SYM))
      sym_class = SYM_END;
    else if (data_in >= DATA_WIDTH'(LUG_MIN) && data_in <= DATA_WIDTH'(LUG_MAX))
      sym_class = SYM_LUGGAGE;
  end

endmodule

// File: rtl/dual_buffer_sched.sv
// Dual-buffer scheduler: routes a symbol stream into an external passenger
// FIFO and luggage stack, then drains the FIFO followed by the stack.
//   clk, reset           : clock, synchronous active-high reset
//   ready, data_in       : upstream symbol handshake / symbol
//   fifo_empty/full      : passenger FIFO status
//   lifo_empty/full      : luggage stack status
//   fifo_wr_en/rd_en     : passenger FIFO push / pop (combinational)
//   lifo_wr_en/rd_en     : luggage stack push / pop (combinational)
//   out_sel              : output mux select, 0 = FIFO, 1 = stack
//   valid                : a popped item is on the output this cycle
//   done, overflow       : sticky status flags
//   pass_cnt, lug_cnt    : saturating acceptance counters
module dual_buffer_sched
  import dual_buffer_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic                  lifo_empty,
  input  logic                  lifo_full,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic                  lifo_wr_en,
  output logic                  lifo_rd_en,
  output logic                  out_sel,
  output logic                  valid,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      lug_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sym_class_e cls;
  state_e     state;

  symbol_classify #(.DATA_WIDTH(DATA_WIDTH)) u_classify (
    .data_in  (data_in),
    .sym_class(cls)
  );

  // Buffer strobes must act in the cycle the symbol is presented, so they
  // are decoded from the current state; reset masks them immediately.
  always_comb begin
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    lifo_wr_en = 1'b0;
    lifo_rd_en = 1'b0;
    out_sel    = 1'b0;
    valid      = 1'b0;
    if (!reset) begin
      case (state)
        ACCEPT: if (ready) begin
          if (cls == SYM_PASSENGER) fifo_wr_en = !fifo_full;
          if (cls == SYM_LUGGAGE)   lifo_wr_en = !lifo_full;
        end
        DRAIN_FIFO: begin
          fifo_rd_en = !fifo_empty;
          valid      = !fifo_empty;
        end
        DRAIN_LIFO: begin
          lifo_rd_en = !lifo_empty;
          valid      = !lifo_empty;
          out_sel    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pass_cnt <= '0;
      lug_cnt  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        // The first valid symbol only wakes the FSM; upstream keeps it.
        IDLE: if (ready) state <= ACCEPT;
        ACCEPT: if (ready) begin
          case (cls)
            SYM_END: state <= DRAIN_FIFO;
            SYM_PASSENGER: begin
              if (fifo_full) overflow <= 1'b1;
              else if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
            end
            SYM_LUGGAGE: begin
              if (lifo_full) overflow <= 1'b1;
              else if (lug_cnt != CNT_MAX) lug_cnt <= lug_cnt + 1'b1;
            end
            default: ;
          endcase
        end
        DRAIN_FIFO: if (fifo_empty) state <= DRAIN_LIFO;
        DRAIN_LIFO: if (lifo_empty) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    done  <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dual_buffer_sched.md
DUAL_BUFFER_SCHED -- requirements
Module: dual_buffer_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 8, symbol width
- CNT_W, 5, width of the pass_cnt and lug_cnt counters
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- ready  in  1  upstream symbol on data_in is valid this cycle
- data_in  in  DATA_WIDTH  ASCII symbol stream
- fifo_empty  in  1  passenger FIFO empty
- fifo_full  in  1  passenger FIFO full
- lifo_empty  in  1  luggage stack empty
- lifo_full  in  1  luggage stack full
- fifo_wr_en  out  1  push data_in into the passenger FIFO
- fifo_rd_en  out  1  pop the passenger FIFO
- lifo_wr_en  out  1  push data_in onto the luggage stack
- lifo_rd_en  out  1  pop the luggage stack
- out_sel  out  1  output mux select: 0 = FIFO, 1 = stack
- valid  out  1  popped data is on the output this cycle
- done  out  1  sequence complete, sticky
- overflow  out  1  a symbol was dropped because its buffer was full, sticky
- pass_cnt  out  CNT_W  passengers accepted
- lug_cnt  out  CNT_W  luggage items accepted

Function
REQ-003 Classification SHALL be: 0x31..0x39 = luggage; 0x24 ('$') = end; any other value = passenger.
REQ-004 The FSM SHALL have five states: IDLE, ACCEPT, DRAIN_FIFO, DRAIN_LIFO, DONE.
REQ-005 IDLE SHALL go to ACCEPT on the first cycle with ready=1. That symbol SHALL NOT be consumed; upstream holds it.
REQ-006 In ACCEPT with ready=1, a passenger SHALL assert fifo_wr_en in the same cycle (combinational) and increment pass_cnt, if fifo_full=0.
REQ-007 In ACCEPT with ready=1, luggage SHALL assert lifo_wr_en in the same cycle and increment lug_cnt, if lifo_full=0.
REQ-008 If the target buffer is full, the symbol SHALL be dropped: no write, counter unchanged, overflow set to 1 on the next edge.
REQ-009 In ACCEPT with ready=1 and an end symbol, the FSM SHALL move to DRAIN_FIFO with no write.
REQ-010 In ACCEPT with ready=0, the FSM SHALL hold state and assert no enables.
REQ-011 In DRAIN_FIFO: fifo_rd_en = valid = !fifo_empty and out_sel=0. When fifo_empty=1, the FSM SHALL go to DRAIN_LIFO.
REQ-012 In DRAIN_LIFO: lifo_rd_en = valid = !lifo_empty and out_sel=1. When lifo_empty=1, the FSM SHALL go to DONE.
REQ-013 DONE SHALL assert done=1 and ignore all inputs until reset.
REQ-014 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-015 Read and write enables SHALL never be active in the same cycle. At most one enable SHALL be high per cycle.
REQ-016 Both buffers empty at the end symbol SHALL give DRAIN_FIFO -> DRAIN_LIFO -> DONE in 2 cycles with valid=0 throughout.

Reset
REQ-017 Reset SHALL be synchronous and active-high, and SHALL override all other inputs on the same edge.
REQ-018 Reset SHALL put the FSM in IDLE and clear pass_cnt, lug_cnt, overflow and done to 0.
REQ-019 During and after reset, all enables, valid and out_sel SHALL be 0.
REQ-020 Reset mid-drain SHALL abort the sequence. The block SHALL NOT clear the external buffers; they reset themselves.

Structure
REQ-021 A shared package SHALL hold:
- the symbol constants LUG_MIN=0x31, LUG_MAX=0x39, END_SYM=0x24
- the 2-bit symbol class encoding: LUGGAGE=00, PASSENGER=01, END=10
- the 3-bit state encoding
REQ-022 One sub-module, symbol_classify, SHALL do the combinational data_in-to-class mapping. All other logic SHALL be in dual_buffer_sched.

Verification
REQ-023 Mixed stream: "A","3","B","$" with both buffers empty ->
- fifo_wr_en for A and B, lifo_wr_en for 3
- then 2 valid FIFO pops, then 1 valid stack pop, then done=1
- pass_cnt=2, lug_cnt=1
REQ-024 ready gaps: ready toggled 1,0,1 during ACCEPT -> no enables in the ready=0 cycle, counts unchanged.
REQ-025 Overflow: fifo_full=1 while "C" is presented -> fifo_wr_en=0, pass_cnt unchanged, overflow=1 on the next cycle and stays 1.
REQ-026 Immediate end: "$" as the first accepted symbol with both buffers empty -> done=1 exactly 2 cycles after ACCEPT, valid never asserted.
REQ-027 Reset mid-drain: reset=1 in DRAIN_FIFO -> next cycle state is IDLE, all outputs 0, done=0.
REQ-028 Saturation: 40 passengers with CNT_W=5 -> pass_cnt holds at 31.
